// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: default widths,
// funct3 encodings and divider FSM states.
package mul_div_unit_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int ROB_ID_WIDTH_DEF = 5;
  localparam int MUL_STAGES_DEF   = 3;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic isDivOp(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic isSignedDiv(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic isRemOp(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider. The DONE state doubles as the pending
// result holder until the top acknowledges emission.
module div_iter
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rstN,
  input  logic            i_adv,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dataJ,
  input  logic [XLEN-1:0] i_dataK,
  input  logic            i_ack,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  localparam int CW = $clog2(XLEN + 1);

  div_state_e      r_state;
  div_state_e      w_nextState;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic            r_negQ;
  logic            r_negR;
  logic            r_special;

  logic [XLEN-1:0] w_absJ;
  logic [XLEN-1:0] w_absK;
  logic            w_divZero;
  logic            w_overflow;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  assign w_absJ     = (i_signed && i_dataJ[XLEN-1]) ? (~i_dataJ + 1'b1) : i_dataJ;
  assign w_absK     = (i_signed && i_dataK[XLEN-1]) ? (~i_dataK + 1'b1) : i_dataK;
  assign w_divZero  = ~|i_dataK;
  assign w_overflow = i_signed && (i_dataJ == {1'b1, {(XLEN-1){1'b0}}}) && (&i_dataK);
  assign w_shift    = {r_rem, r_quot[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) r_state <= DIV_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (i_adv) begin
      if (i_flush) begin
        w_nextState = DIV_IDLE;
      end else begin
        case (r_state)
          DIV_IDLE: if (i_start) w_nextState = DIV_CALC;
          DIV_CALC: if (r_count == CW'(1)) w_nextState = DIV_DONE;
          DIV_DONE: if (i_ack) w_nextState = DIV_IDLE;
          default:  w_nextState = DIV_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_busy = (r_state != DIV_IDLE);
    o_done = (r_state == DIV_DONE);
    o_quot = r_negQ ? (~r_quot + 1'b1) : r_quot;
    o_rem  = r_negR ? (~r_rem + 1'b1) : r_rem;
  end

  // Special cases still spend one CALC cycle so they finish two edges after issue.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_count   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_special <= 1'b0;
    end else if (i_adv && !i_flush) begin
      if (r_state == DIV_IDLE && i_start) begin
        r_divisor <= w_absK;
        if (w_divZero) begin
          r_quot    <= '1;
          r_rem     <= i_dataJ;
          r_negQ    <= 1'b0;
          r_negR    <= 1'b0;
          r_count   <= CW'(1);
          r_special <= 1'b1;
        end else if (w_overflow) begin
          r_quot    <= i_dataJ;
          r_rem     <= '0;
          r_negQ    <= 1'b0;
          r_negR    <= 1'b0;
          r_count   <= CW'(1);
          r_special <= 1'b1;
        end else begin
          r_quot    <= w_absJ;
          r_rem     <= '0;
          r_negQ    <= i_signed && (i_dataJ[XLEN-1] ^ i_dataK[XLEN-1]);
          r_negR    <= i_signed && i_dataJ[XLEN-1];
          r_count   <= CW'(XLEN);
          r_special <= 1'b0;
        end
      end else if (r_state == DIV_CALC) begin
        r_count <= r_count - CW'(1);
        if (!r_special) begin
          if (!w_diff[XLEN]) begin
            r_rem  <= w_diff[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b1};
          end else begin
            r_rem  <= w_shift[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execution unit: pipelined multiplier plus iterative divider sharing one
// result port; multiplier exits win collisions and the divider waits in DONE.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF,
  parameter int MUL_STAGES   = MUL_STAGES_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    en,
  input  logic [2:0]              op,
  input  logic [ROB_ID_WIDTH-1:0] rob_id,
  input  logic [XLEN-1:0]         data_j,
  input  logic [XLEN-1:0]         data_k,
  output logic                    div_busy,
  output logic                    rdy,
  output logic [ROB_ID_WIDTH-1:0] rob_id_out,
  output logic [XLEN-1:0]         result
);

  logic                    w_issue;
  logic                    w_issueMul;
  logic                    w_issueDiv;
  logic                    w_divBusy;
  logic                    w_divDone;
  logic                    w_divAck;
  logic [XLEN-1:0]         w_divQuot;
  logic [XLEN-1:0]         w_divRem;
  logic                    w_mulExit;
  logic                    w_signJ;
  logic                    w_signK;
  logic [2*XLEN-1:0]       w_mulA;
  logic [2*XLEN-1:0]       w_mulB;
  logic [2*XLEN-1:0]       w_prod;
  logic [XLEN-1:0]         w_mulRes;

  logic                    r_pV   [MUL_STAGES];
  logic [ROB_ID_WIDTH-1:0] r_pTag [MUL_STAGES];
  logic [XLEN-1:0]         r_pRes [MUL_STAGES];
  logic [ROB_ID_WIDTH-1:0] r_divTag;
  logic                    r_divIsRem;
  logic                    r_rdy;
  logic [ROB_ID_WIDTH-1:0] r_robOut;
  logic [XLEN-1:0]         r_result;

  assign w_issue    = en && rdy_in && !flush;
  assign w_issueMul = w_issue && !isDivOp(op);
  assign w_issueDiv = w_issue && isDivOp(op) && !w_divBusy;
  assign w_mulExit  = r_pV[MUL_STAGES-1];
  assign w_divAck   = rdy_in && !flush && w_divDone && !w_mulExit;

  // Sign-extending both operands to 2*XLEN lets one unsigned multiply serve all four variants.
  assign w_signJ  = (op == OP_MULH) || (op == OP_MULHSU);
  assign w_signK  = (op == OP_MULH);
  assign w_mulA   = {{XLEN{w_signJ && data_j[XLEN-1]}}, data_j};
  assign w_mulB   = {{XLEN{w_signK && data_k[XLEN-1]}}, data_k};
  assign w_prod   = w_mulA * w_mulB;
  assign w_mulRes = (op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_pV[i]   <= 1'b0;
        r_pTag[i] <= '0;
        r_pRes[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < MUL_STAGES; i++) r_pV[i] <= 1'b0;
      end else begin
        r_pV[0]   <= w_issueMul;
        r_pTag[0] <= rob_id;
        r_pRes[0] <= w_mulRes;
        for (int i = 1; i < MUL_STAGES; i++) begin
          r_pV[i]   <= r_pV[i-1];
          r_pTag[i] <= r_pTag[i-1];
          r_pRes[i] <= r_pRes[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_divTag   <= '0;
      r_divIsRem <= 1'b0;
    end else if (w_issueDiv) begin
      r_divTag   <= rob_id;
      r_divIsRem <= isRemOp(op);
    end
  end

  div_iter #(.XLEN(XLEN)) u_divIter (
    .i_clk    (clk_in),
    .i_rstN   (rst_n_in),
    .i_adv    (rdy_in),
    .i_flush  (flush),
    .i_start  (w_issueDiv),
    .i_signed (isSignedDiv(op)),
    .i_dataJ  (data_j),
    .i_dataK  (data_k),
    .i_ack    (w_divAck),
    .o_busy   (w_divBusy),
    .o_done   (w_divDone),
    .o_quot   (w_divQuot),
    .o_rem    (w_divRem)
  );

  // Tag and result keep their last value whenever no op completes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rdy    <= 1'b0;
      r_robOut <= '0;
      r_result <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_rdy <= 1'b0;
      end else if (w_mulExit) begin
        r_rdy    <= 1'b1;
        r_robOut <= r_pTag[MUL_STAGES-1];
        r_result <= r_pRes[MUL_STAGES-1];
      end else if (w_divDone) begin
        r_rdy    <= 1'b1;
        r_robOut <= r_divTag;
        r_result <= r_divIsRem ? w_divRem : w_divQuot;
      end else begin
        r_rdy <= 1'b0;
      end
    end
  end

  assign div_busy   = w_divBusy;
  assign rdy        = r_rdy;
  assign rob_id_out = r_robOut;
  assign result     = r_result;

endmodule
